alu_mc_hs: RTL and testbench
============================

// Module: alu_mc_hs
// PURPOSE
//  Multi-cycle, parametrised ALU for the UART system: same 4-bit op set, plus remainder
//   and divide-by-zero reporting. Valid/ready handshake on request and result sides.
//  Division is an iterative restoring divider (1 quotient bit/cycle); all other ops take 1 cycle.
//  Sits between the register-file/command controller and the TX result path.
// PARAMETERS
//  WIDTH   8   operand width (>=2); result width is 2*WIDTH; counter width $clog2(WIDTH+1)
// PORTS
//  ALU_CLK    in   1        clock, rising edge
//  ALU_RST    in   1        asynchronous, active-low reset
//  A          in   WIDTH    operand A, sampled only on accept
//  B          in   WIDTH    operand B, sampled only on accept
//  ALU_FUN    in   4        opcode, sampled only on accept
//  ALU_en     in   1        request valid
//  ALU_RDY    out  1        request ready; accept = ALU_en & ALU_RDY at rising edge
//  ALU_OUT    out  2*WIDTH  result, held stable while ALU_Valid=1 and ALU_ACK=0
//  ALU_Valid  out  1        result valid
//  ALU_ACK    in   1        consumer ready; result consumed = ALU_Valid & ALU_ACK at edge
//  ALU_ERR    out  1        qualified by ALU_Valid: divide/remainder by zero
//  ALU_BUSY   out  1        1 while in DIV state
// BEHAVIOUR
//  Reset (async, ALU_RST=0): state IDLE, ALU_OUT=0, ALU_Valid=0, ALU_ERR=0, ALU_BUSY=0,
//   counter=0, operand latches=0. Reset mid-division aborts it; no result is produced.
//  FSM: IDLE, DIV, HOLD.
//   ALU_RDY = (state==IDLE) | (state==HOLD & ALU_ACK) (combinational).
//   IDLE/HOLD + accept, op!=DIV/REM, or B==0: result registered at the accept edge -> HOLD.
//   IDLE/HOLD + accept, DIV/REM with B!=0: latch A,B -> DIV, counter=WIDTH.
//   HOLD + ALU_ACK, no accept -> IDLE; HOLD, no ALU_ACK -> stay, outputs frozen.
//   DIV: one restoring step/edge, counter--; on the edge where counter reaches 0, load
//        ALU_OUT, ALU_Valid=1 -> HOLD. Latency: accept at edge k -> ALU_Valid after edge k+WIDTH.
//   Back-to-back: result consumed and new request accepted on the same edge in HOLD.
//  ALU_Valid rises on the edge that enters HOLD, falls on consume edge unless a 1-cycle op
//   is accepted on that same edge (stays 1, new data). ALU_ERR updates with ALU_OUT.
//  Opcodes (A,B unsigned; zero-extended to 2*WIDTH unless stated):
//   0000 A+B (carry lands in bit WIDTH)  0001 A-B mod 2^(2W) (A<B -> upper bits all 1)
//   0010 A*B full product  0011 A/B quotient  0100 AND  0101 OR  0110 NAND  0111 NOR
//   1000 XOR  1001 XNOR  (NAND/NOR/XNOR: WIDTH-bit result, upper WIDTH bits 0)
//   1010 A==B ? 1 : 0   1011 A>B ? 2 : 0   1100 A<B ? 3 : 0
//   1101 A>>1 logical   1110 A<<1 (bit WIDTH keeps shifted-out MSB)   1111 A%B remainder
//  Divide/remainder by zero: 1-cycle latency, ALU_ERR=1; 0011 -> {W'b0,{W{1'b1}}}, 1111 -> A.
//  ALU_ERR=0 for every other result. Inputs A/B/ALU_FUN ignored while not accepting.
//  ALU_en high while ALU_RDY=0: request stalls (held by producer), nothing latched.
// TESTING
//  1) WIDTH=8; A=200,B=100,FUN=0000, ACK=1 -> next edge ALU_Valid=1, ALU_OUT=16'd300, ERR=0.
//  2) A=5,B=9,FUN=0001 -> ALU_OUT=16'hFFFC; FUN=0010, A=255,B=255 -> 16'hFE01.
//  3) A=200,B=7,FUN=0011 -> ALU_BUSY=1 for 8 cycles, ALU_RDY=0, then ALU_OUT=28; FUN=1111 -> 4.
//  4) A=17,B=0,FUN=0011 -> 1 cycle, ALU_OUT=16'h00FF, ALU_ERR=1; FUN=1111 -> ALU_OUT=17, ERR=1.
//  5) ACK=0 for 5 cycles after result of 1011 (A=9,B=3): ALU_OUT=2 stable, ALU_RDY=0;
//     then ACK=1 with ALU_en=1, FUN=1010, A=B=4 -> same edge consumes, next ALU_OUT=1, Valid stays 1.
//  6) Drop ALU_RST at 4th DIV cycle -> all outputs 0 immediately; after release, IDLE, ALU_RDY=1,
//     no stale ALU_Valid. Repeat 1-5 with WIDTH=16 and random ops vs reference model.

Source files
------------

// File: rtl/alu_mc_hs_if.sv
// Request/result handshake bundle for the multi-cycle ALU.
// master = producer/consumer side, slave = ALU side.
interface alu_mc_hs_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [3:0]         ALU_FUN;
    logic               ALU_en;
    logic               ALU_RDY;
    logic [2*WIDTH-1:0] ALU_OUT;
    logic               ALU_Valid;
    logic               ALU_ACK;
    logic               ALU_ERR;
    logic               ALU_BUSY;

    modport master (
        output A, B, ALU_FUN, ALU_en, ALU_ACK,
        input  ALU_RDY, ALU_OUT, ALU_Valid, ALU_ERR, ALU_BUSY
    );

    modport slave (
        input  A, B, ALU_FUN, ALU_en, ALU_ACK,
        output ALU_RDY, ALU_OUT, ALU_Valid, ALU_ERR, ALU_BUSY
    );
endinterface

// File: rtl/alu_mc_hs.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Division/remainder uses a restoring divider, one quotient bit per cycle.
module alu_mc_hs #(
    parameter int WIDTH = 8
) (
    input  logic        ALU_CLK,
    input  logic        ALU_RST,
    alu_mc_hs_if.slave  bus
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;

    state_t           state_q, state_d;
    logic [W2-1:0]    out_q, out_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             is_rem_q, is_rem_d;

    logic [WIDTH-1:0] a, b;
    logic [W2-1:0]    a_x, b_x;
    logic [W2-1:0]    res;
    logic             res_err;
    logic             rdy, accept, is_div, long_op;
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] rem_n, quo_n;

    assign a      = bus.A;
    assign b      = bus.B;
    assign a_x    = {{WIDTH{1'b0}}, a};
    assign b_x    = {{WIDTH{1'b0}}, b};
    assign rdy    = (state_q == IDLE) | ((state_q == HOLD) & bus.ALU_ACK);
    assign accept = bus.ALU_en & rdy;
    assign is_div = (bus.ALU_FUN == 4'h3) | (bus.ALU_FUN == 4'hF);
    assign long_op = is_div & (b != '0);

    always_comb begin
        res     = '0;
        res_err = 1'b0;
        case (bus.ALU_FUN)
            4'h0: res = a_x + b_x;
            4'h1: res = a_x - b_x;
            4'h2: res = a_x * b_x;
            4'h3: if (b == '0) begin
                res     = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                res_err = 1'b1;
            end
            4'h4: res = a_x & b_x;
            4'h5: res = a_x | b_x;
            4'h6: res = {{WIDTH{1'b0}}, ~(a & b)};
            4'h7: res = {{WIDTH{1'b0}}, ~(a | b)};
            4'h8: res = a_x ^ b_x;
            4'h9: res = {{WIDTH{1'b0}}, ~(a ^ b)};
            4'hA: res = (a == b) ? W2'(1) : '0;
            4'hB: res = (a > b) ? W2'(2) : '0;
            4'hC: res = (a < b) ? W2'(3) : '0;
            4'hD: res = a_x >> 1;
            4'hE: res = a_x << 1;
            4'hF: if (b == '0) begin
                res     = a_x;
                res_err = 1'b1;
            end
            default: res = '0;
        endcase
    end

    // Restoring step; the partial remainder is always below the divisor,
    // so the W-bit modular difference is exact.
    assign trial = {rem_q, quo_q[WIDTH-1]};
    assign ge    = trial >= {1'b0, dvs_q};
    assign rem_n = ge ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
    assign quo_n = {quo_q[WIDTH-2:0], ge};

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        valid_d  = valid_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        is_rem_d = is_rem_q;
        case (state_q)
            IDLE, HOLD: begin
                if (state_q == HOLD && bus.ALU_ACK) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
                if (accept) begin
                    if (long_op) begin
                        quo_d    = a;
                        dvs_d    = b;
                        rem_d    = '0;
                        is_rem_d = bus.ALU_FUN[2];
                        cnt_d    = CW'(WIDTH);
                        valid_d  = 1'b0;
                        state_d  = DIV;
                    end else begin
                        out_d   = res;
                        err_d   = res_err;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            DIV: begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    out_d   = {{WIDTH{1'b0}}, is_rem_q ? rem_n : quo_n};
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ALU_CLK or negedge ALU_RST) begin
        if (!ALU_RST) begin
            state_q  <= IDLE;
            out_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            is_rem_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            is_rem_q <= is_rem_d;
        end
    end

    assign bus.ALU_RDY   = rdy;
    assign bus.ALU_OUT   = out_q;
    assign bus.ALU_Valid = valid_q;
    assign bus.ALU_ERR   = err_q;
    assign bus.ALU_BUSY  = (state_q == DIV);
endmodule

// File: tb/tb_alu_mc_hs.sv
// Scoreboard bench for alu_mc_hs: directed cases then random traffic,
// expected results from an arithmetic reference model.
module tb_alu_mc_hs;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_mc_hs_if #(.WIDTH(W)) bus ();

    alu_mc_hs #(.WIDTH(W)) dut (
        .ALU_CLK (clk),
        .ALU_RST (rst_n),
        .bus     (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    logic [2*W:0] exp_q[$];
    bit rand_ack = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [3:0] f);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint m1 = (longint'(1) << W) - 1;
        longint m2 = (longint'(1) << (2 * W)) - 1;
        longint r = 0;
        logic e = 1'b0;
        case (f)
            4'h0: r = ua + ub;
            4'h1: r = (ua - ub) & m2;
            4'h2: r = ua * ub;
            4'h3: if (ub == 0) begin r = m1; e = 1'b1; end else r = ua / ub;
            4'h4: r = ua & ub;
            4'h5: r = ua | ub;
            4'h6: r = (~(ua & ub)) & m1;
            4'h7: r = (~(ua | ub)) & m1;
            4'h8: r = ua ^ ub;
            4'h9: r = (~(ua ^ ub)) & m1;
            4'hA: r = (ua == ub) ? 1 : 0;
            4'hB: r = (ua > ub) ? 2 : 0;
            4'hC: r = (ua < ub) ? 3 : 0;
            4'hD: r = ua / 2;
            4'hE: r = ua * 2;
            4'hF: if (ub == 0) begin r = ua; e = 1'b1; end else r = ua % ub;
            default: r = 0;
        endcase
        return {e, r[2*W-1:0]};
    endfunction

    // Monitor: each result is checked once, on the cycle it is consumed.
    logic           held_v = 1'b0;
    logic [2*W-1:0] held_out;
    logic           held_err;
    initial begin
        logic [2*W:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_v = 1'b0;
            end else if (bus.ALU_Valid) begin
                if (held_v) begin
                    chk("hold_out", bus.ALU_OUT, held_out);
                    chk("hold_err", bus.ALU_ERR, held_err);
                end
                if (bus.ALU_ACK) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got %0h expected none", bus.ALU_OUT);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", bus.ALU_OUT, e[2*W-1:0]);
                        chk("err", bus.ALU_ERR, e[2*W]);
                    end
                    held_v = 1'b0;
                end else begin
                    held_v   = 1'b1;
                    held_out = bus.ALU_OUT;
                    held_err = bus.ALU_ERR;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ack) bus.ALU_ACK = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] f);
        int n = 0;
        bit ok = 1'b0;
        bus.ALU_en  = 1'b1;
        bus.A       = a;
        bus.B       = b;
        bus.ALU_FUN = f;
        while (!ok && n <= 200) begin
            @(negedge clk);
            if (bus.ALU_RDY) ok = 1'b1;
            else begin
                n++;
                tick();
            end
        end
        if (ok) begin
            exp_q.push_back(model(a, b, f));
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no ALU_RDY expected accept within 200 cycles");
        end
        tick();
        bus.ALU_en  = 1'b0;
        bus.A       = W'($urandom);
        bus.B       = W'($urandom);
        bus.ALU_FUN = 4'($urandom);
    endtask

    task automatic busy_cycles();
        int n = 0;
        bit done = 1'b0;
        while (!done && n < 100) begin
            @(negedge clk);
            if (bus.ALU_BUSY) begin
                chk("busy_rdy", bus.ALU_RDY, 0);
                n++;
            end else begin
                done = 1'b1;
            end
        end
        chk("div_busy_cycles", n, W);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [W-1:0] ra, rb;
        bus.ALU_en  = 1'b0;
        bus.A       = '0;
        bus.B       = '0;
        bus.ALU_FUN = '0;
        bus.ALU_ACK = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out", bus.ALU_OUT, 0);
        chk("rst_valid", bus.ALU_Valid, 0);
        chk("rst_err", bus.ALU_ERR, 0);
        chk("rst_busy", bus.ALU_BUSY, 0);
        chk("rst_rdy", bus.ALU_RDY, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.ALU_ACK = 1'b1;
        tick();

        send(8'd200, 8'd100, 4'h0);
        send(8'd5, 8'd9, 4'h1);
        send(8'd255, 8'd255, 4'h2);
        send(8'd200, 8'd7, 4'h3);
        busy_cycles();
        send(8'd200, 8'd7, 4'hF);
        busy_cycles();
        send(8'd17, 8'd0, 4'h3);
        send(8'd17, 8'd0, 4'hF);
        send(8'd5, 8'd0, 4'h0);
        send(8'd128, 8'd0, 4'hE);
        tick();

        bus.ALU_ACK = 1'b0;
        send(8'd9, 8'd3, 4'hB);
        repeat (5) begin
            @(negedge clk);
            chk("hold_rdy", bus.ALU_RDY, 0);
            chk("hold_valid", bus.ALU_Valid, 1);
            tick();
        end
        bus.ALU_ACK = 1'b1;
        send(8'd4, 8'd4, 4'hA);
        @(negedge clk);
        chk("b2b_valid", bus.ALU_Valid, 1);
        tick();
        tick();

        send(8'd200, 8'd7, 4'h3);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out", bus.ALU_OUT, 0);
        chk("midrst_valid", bus.ALU_Valid, 0);
        chk("midrst_busy", bus.ALU_BUSY, 0);
        chk("midrst_err", bus.ALU_ERR, 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", bus.ALU_RDY, 1);
        repeat (W + 4) begin
            @(negedge clk);
            chk("post_rst_valid", bus.ALU_Valid, 0);
        end
        tick();

        rand_ack = 1'b1;
        repeat (300) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            send(ra, rb, 4'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_ack = 1'b0;
        bus.ALU_ACK = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        @(negedge clk);
        chk("final_valid", bus.ALU_Valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
